// File: rtl/evu_event_filter_fifo.sv
// ---------------------------------------------------------------------------
// evu_event_filter_fifo
//
// Event unit sitting between the core event sources and the SPU. Each channel
// picks one raw event strobe and qualifies it with a privilege mask. A set of
// commit-PC range comparators flags commits that fall inside a configured
// window. Every cycle with at least one channel fire or a PC hit becomes one
// {e_id, e_info} record. Records go through a small FIFO with a valid/ready
// output. Records that arrive while the FIFO is full are counted as drops.
//
// Pipeline: inputs of cycle N are qualified and registered at edge N+1. The
// record is pushed at edge N+2. There is no bypass path from the inputs to
// the FIFO output.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   evt_i          raw single-cycle event strobes
//   commit_vld_i   pc_commit_i is valid this cycle
//   pc_commit_i    committing PC (VLEN bits)
//   priv_lvl_i     privilege: 01 M, 10 S, 11 U
//   asid_i         current ASID
//   debug_mode_i   core in debug mode; suppresses all events
//   cfg_we_i       config write strobe
//   cfg_re_i       config read strobe
//   cfg_addr_i     config word address
//   cfg_wdata_i    config write data
//   cfg_rdata_o    config read data, valid the cycle after cfg_re_i
//   out_valid_o    FIFO head valid
//   out_ready_i    consumer accepts the head
//   out_e_id_o     {pc_hit, ch_fire[NUM_CH-1:0]}
//   out_e_info_o   {pc_idx, priv, asid}
//   overflow_o     sticky flag: a record was dropped
//
// Config map (word addresses)
//   0x00       CTRL: [0] enable, [1] clear drops (write-1), [31] overflow (RO)
//   0x01       DROP_CNT (RO, saturating)
//   0x08+i     CH_i: [EVT_SEL_W-1:0] sel, [16] M, [17] S, [18] U, [31] enable
//   0x20+4k+j  PC_k: j=0 lo[31:0], 1 lo[VLEN-1:32], 2 hi[31:0], 3 hi[VLEN-1:32]
// ---------------------------------------------------------------------------
module evu_event_filter_fifo #(
    parameter int NUM_EVT    = 16,
    parameter int NUM_CH     = 4,
    parameter int NUM_PC     = 4,
    parameter int ASID_WIDTH = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CFG_AW     = 6,
    parameter int VLEN       = 64,
    localparam int EVT_SEL_W = $clog2(NUM_EVT),
    localparam int PC_IDX_W  = (NUM_PC > 1) ? $clog2(NUM_PC) : 1,
    localparam int E_ID_W    = NUM_CH + 1,
    localparam int E_INFO_W  = PC_IDX_W + 2 + ASID_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_EVT-1:0]    evt_i,
    input  logic                  commit_vld_i,
    input  logic [VLEN-1:0]       pc_commit_i,
    input  logic [1:0]            priv_lvl_i,
    input  logic [ASID_WIDTH-1:0] asid_i,
    input  logic                  debug_mode_i,
    input  logic                  cfg_we_i,
    input  logic                  cfg_re_i,
    input  logic [CFG_AW-1:0]     cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    output logic [31:0]           cfg_rdata_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [E_ID_W-1:0]     out_e_id_o,
    output logic [E_INFO_W-1:0]   out_e_info_o,
    output logic                  overflow_o
);

    localparam int HI_W  = VLEN - 32;
    localparam int REC_W = E_ID_W + E_INFO_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic                 r_en;
    logic [EVT_SEL_W-1:0] r_ch_sel  [NUM_CH];
    logic [2:0]           r_ch_mask [NUM_CH];   // {U, S, M}
    logic [NUM_CH-1:0]    r_ch_en;
    logic [VLEN-1:0]      r_pc_lo   [NUM_PC];
    logic [VLEN-1:0]      r_pc_hi   [NUM_PC];
    logic [31:0]          r_drop_cnt;
    logic                 r_ovf;
    logic [31:0]          r_rdata;

    logic                 w_clr;
    logic [31:0]          w_rd_val;

    assign w_clr = cfg_we_i && (cfg_addr_i == CFG_AW'(0)) && cfg_wdata_i[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en    <= 1'b0;
            r_ch_en <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_ch_sel[i]  <= '0;
                r_ch_mask[i] <= '0;
            end
            for (int k = 0; k < NUM_PC; k++) begin
                r_pc_lo[k] <= '0;
                r_pc_hi[k] <= '0;
            end
        end else if (cfg_we_i) begin
            if (cfg_addr_i == CFG_AW'(0)) begin
                r_en <= cfg_wdata_i[0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_addr_i == CFG_AW'(8 + i)) begin
                    r_ch_sel[i]  <= cfg_wdata_i[EVT_SEL_W-1:0];
                    r_ch_mask[i] <= cfg_wdata_i[18:16];
                    r_ch_en[i]   <= cfg_wdata_i[31];
                end
            end
            for (int k = 0; k < NUM_PC; k++) begin
                if (cfg_addr_i == CFG_AW'(32 + 4*k)) begin
                    r_pc_lo[k][31:0] <= cfg_wdata_i;
                end
                if (cfg_addr_i == CFG_AW'(33 + 4*k)) begin
                    r_pc_lo[k][VLEN-1:32] <= cfg_wdata_i[HI_W-1:0];
                end
                if (cfg_addr_i == CFG_AW'(34 + 4*k)) begin
                    r_pc_hi[k][31:0] <= cfg_wdata_i;
                end
                if (cfg_addr_i == CFG_AW'(35 + 4*k)) begin
                    r_pc_hi[k][VLEN-1:32] <= cfg_wdata_i[HI_W-1:0];
                end
            end
        end
    end

    // Read mux; anything not decoded reads as zero.
    always_comb begin
        w_rd_val = '0;
        if (cfg_addr_i == CFG_AW'(0)) begin
            w_rd_val[0]  = r_en;
            w_rd_val[31] = r_ovf;
        end
        if (cfg_addr_i == CFG_AW'(1)) begin
            w_rd_val = r_drop_cnt;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_addr_i == CFG_AW'(8 + i)) begin
                w_rd_val[EVT_SEL_W-1:0] = r_ch_sel[i];
                w_rd_val[18:16]         = r_ch_mask[i];
                w_rd_val[31]            = r_ch_en[i];
            end
        end
        for (int k = 0; k < NUM_PC; k++) begin
            if (cfg_addr_i == CFG_AW'(32 + 4*k)) begin
                w_rd_val = r_pc_lo[k][31:0];
            end
            if (cfg_addr_i == CFG_AW'(33 + 4*k)) begin
                w_rd_val[HI_W-1:0] = r_pc_lo[k][VLEN-1:32];
            end
            if (cfg_addr_i == CFG_AW'(34 + 4*k)) begin
                w_rd_val = r_pc_hi[k][31:0];
            end
            if (cfg_addr_i == CFG_AW'(35 + 4*k)) begin
                w_rd_val[HI_W-1:0] = r_pc_hi[k][VLEN-1:32];
            end
        end
    end

    // Read data returns to zero when no read is in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (cfg_re_i) begin
            r_rdata <= w_rd_val;
        end else begin
            r_rdata <= '0;
        end
    end

    assign cfg_rdata_o = r_rdata;

    // ------------------------------------------------------------------
    // Stage 1: qualify events and PC commits
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]     w_priv_ok;
    logic [NUM_CH-1:0]     w_fire;
    logic [NUM_PC-1:0]     w_pc_match;
    logic                  w_pc_hit;
    logic [PC_IDX_W-1:0]   w_pc_idx;

    always_comb begin
        w_priv_ok = '0;
        w_fire    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (priv_lvl_i)
                2'b01:   w_priv_ok[i] = r_ch_mask[i][0];
                2'b10:   w_priv_ok[i] = r_ch_mask[i][1];
                2'b11:   w_priv_ok[i] = r_ch_mask[i][2];
                default: w_priv_ok[i] = 1'b0;
            endcase
            w_fire[i] = r_en & r_ch_en[i] & evt_i[r_ch_sel[i]] & w_priv_ok[i]
                        & ~debug_mode_i;
        end
    end

    // Half-open window lo <= pc < hi; an inverted or empty window (hi <= lo)
    // can never satisfy both bounds. Scanning downwards leaves the lowest
    // matching comparator index in w_pc_idx.
    always_comb begin
        w_pc_match = '0;
        w_pc_idx   = '0;
        for (int k = NUM_PC - 1; k >= 0; k--) begin
            w_pc_match[k] = (pc_commit_i >= r_pc_lo[k]) && (pc_commit_i < r_pc_hi[k]);
            if (w_pc_match[k]) begin
                w_pc_idx = PC_IDX_W'(k);
            end
        end
        w_pc_hit = r_en & commit_vld_i & ~debug_mode_i & (|w_pc_match);
        if (!w_pc_hit) begin
            w_pc_idx = '0;
        end
    end

    logic [NUM_CH-1:0]     r_s1_fire;
    logic                  r_s1_hit;
    logic [PC_IDX_W-1:0]   r_s1_idx;
    logic [1:0]            r_s1_priv;
    logic [ASID_WIDTH-1:0] r_s1_asid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_fire <= '0;
            r_s1_hit  <= 1'b0;
            r_s1_idx  <= '0;
            r_s1_priv <= '0;
            r_s1_asid <= '0;
        end else begin
            r_s1_fire <= w_fire;
            r_s1_hit  <= w_pc_hit;
            r_s1_idx  <= w_pc_idx;
            r_s1_priv <= priv_lvl_i;
            r_s1_asid <= asid_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: record FIFO
    // ------------------------------------------------------------------
    logic [REC_W-1:0]  w_rec;
    logic              w_push;
    logic              w_full;
    logic              w_valid;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_drop;

    logic [REC_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    assign w_rec     = {r_s1_hit, r_s1_fire, r_s1_idx, r_s1_priv, r_s1_asid};
    assign w_push    = r_s1_hit | (|r_s1_fire);
    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid & out_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the head is masked to zero whenever it is empty.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    logic [REC_W-1:0] w_head;

    assign w_head       = w_valid ? r_mem[r_rd_ptr] : '0;
    assign out_valid_o  = w_valid;
    assign out_e_id_o   = w_head[REC_W-1:E_INFO_W];
    assign out_e_info_o = w_head[E_INFO_W-1:0];

    // ------------------------------------------------------------------
    // Drop accounting; a clear in the same cycle as a drop wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_clr) begin
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_drop) begin
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            r_ovf <= 1'b1;
        end
    end

    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_evu_event_filter_fifo.sv
module tb_evu_event_filter_fifo;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] evt_i = '0;
    logic        commit_vld_i = 1'b0;
    logic [63:0] pc_commit_i = '0;
    logic [1:0]  priv_lvl_i = 2'b01;
    logic [0:0]  asid_i = '0;
    logic        debug_mode_i = 1'b0;
    logic        cfg_we_i = 1'b0;
    logic        cfg_re_i = 1'b0;
    logic [5:0]  cfg_addr_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic [31:0] cfg_rdata_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [4:0]  out_e_id_o;
    logic [4:0]  out_e_info_o;
    logic        overflow_o;

    int n_cmp = 0;
    int n_err = 0;

    evu_event_filter_fifo dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .evt_i        (evt_i),
        .commit_vld_i (commit_vld_i),
        .pc_commit_i  (pc_commit_i),
        .priv_lvl_i   (priv_lvl_i),
        .asid_i       (asid_i),
        .debug_mode_i (debug_mode_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_re_i     (cfg_re_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_e_id_o   (out_e_id_o),
        .out_e_info_o (out_e_info_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
        cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic cfg_read(input logic [5:0] a, output logic [31:0] d);
        cfg_re_i = 1'b1; cfg_addr_i = a;
        tick();
        cfg_re_i = 1'b0;
        d = cfg_rdata_o;
    endtask

    // One stimulus cycle, then check the FIFO head at N+1 (must be empty) and N+2.
    task automatic one_shot(input string tag, input logic [15:0] ev, input logic cv,
                            input logic [63:0] pc, input logic [1:0] pl, input logic dbg,
                            input logic asid, input logic exp_v, input logic [4:0] exp_id,
                            input logic [4:0] exp_info);
        evt_i = ev; commit_vld_i = cv; pc_commit_i = pc; priv_lvl_i = pl;
        debug_mode_i = dbg; asid_i = asid;
        tick();
        evt_i = '0; commit_vld_i = 1'b0; debug_mode_i = 1'b0; priv_lvl_i = 2'b01;
        chk({tag, "_n1_valid"}, out_valid_o, 1'b0);
        tick();
        chk({tag, "_valid"}, out_valid_o, exp_v);
        if (exp_v) begin
            chk({tag, "_id"}, out_e_id_o, exp_id);
            chk({tag, "_info"}, out_e_info_o, exp_info);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk({tag, "_drained"}, out_valid_o, 1'b0);
    endtask

    // Fire n back-to-back channel-0 events in M mode with asid alternating 0,1,...
    task automatic fire_burst(input int n);
        for (int k = 0; k < n; k++) begin
            evt_i = 16'h0008; priv_lvl_i = 2'b01; asid_i = k[0];
            tick();
        end
        evt_i = '0; asid_i = '0;
        tick();
        tick();
    endtask

    logic [31:0] rd;
    logic [4:0]  exp_id   [4];
    logic [4:0]  exp_info [4];

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_id", out_e_id_o, 5'd0);
        chk("rst_info", out_e_info_o, 5'd0);
        chk("rst_rdata", cfg_rdata_o, 32'd0);
        chk("rst_ovf", overflow_o, 1'b0);
        rst_ni = 1'b1;
        tick();
        cfg_read(6'h01, rd); chk("rst_dropcnt", rd, 32'd0);
        cfg_read(6'h00, rd); chk("rst_ctrl", rd, 32'd0);

        // Global enable off: nothing fires even with a configured channel.
        cfg_write(6'h08, 32'h8001_0003);
        one_shot("disabled", 16'h0008, 1'b0, 64'd0, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);

        cfg_write(6'h00, 32'h0000_0001);
        cfg_read(6'h08, rd); chk("ch0_readback", rd, 32'h8001_0003);
        cfg_read(6'h05, rd); chk("unmapped_read", rd, 32'd0);

        // Basic channel fire: id=00001, info={00,01,1}
        one_shot("m_fire", 16'h0008, 1'b0, 64'd0, 2'b01, 1'b0, 1'b1, 1'b1, 5'b00001, 5'b00011);
        one_shot("u_masked", 16'h0008, 1'b0, 64'd0, 2'b11, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        one_shot("debug", 16'h0008, 1'b0, 64'd0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        one_shot("wrong_evt", 16'h0004, 1'b0, 64'd0, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);

        // PC ranges: PC0=[0x8000_0000,0x8000_0100), PC2=[0x8000_0080,0x8000_0200)
        cfg_write(6'h20, 32'h8000_0000);
        cfg_write(6'h22, 32'h8000_0100);
        cfg_write(6'h28, 32'h8000_0080);
        cfg_write(6'h2A, 32'h8000_0200);
        cfg_read(6'h2A, rd); chk("pc2_hi_readback", rd, 32'h8000_0200);
        cfg_read(6'h2B, rd); chk("pc2_hi_upper", rd, 32'd0);
        one_shot("pc_090", 16'h0, 1'b1, 64'h8000_0090, 2'b01, 1'b0, 1'b0, 1'b1, 5'b10000, 5'b00010);
        one_shot("pc_100", 16'h0, 1'b1, 64'h8000_0100, 2'b01, 1'b0, 1'b0, 1'b1, 5'b10000, 5'b10010);
        one_shot("pc_200", 16'h0, 1'b1, 64'h8000_0200, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        one_shot("pc_novld", 16'h0, 1'b0, 64'h8000_0090, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);

        // Backpressure: 6 records into a 4-deep FIFO, record 1 also hits PC2.
        for (int k = 0; k < 6; k++) begin
            evt_i = 16'h0008; priv_lvl_i = 2'b01; asid_i = k[0];
            commit_vld_i = (k == 1); pc_commit_i = 64'h8000_0100;
            tick();
        end
        evt_i = '0; commit_vld_i = 1'b0; asid_i = '0;
        tick(); tick();
        chk("bp_ovf", overflow_o, 1'b1);
        cfg_read(6'h01, rd); chk("bp_dropcnt", rd, 32'd2);
        cfg_read(6'h00, rd); chk("bp_ctrl", rd, 32'h8000_0001);
        exp_id[0] = 5'b00001; exp_info[0] = 5'b00010;
        exp_id[1] = 5'b10001; exp_info[1] = 5'b10011;
        exp_id[2] = 5'b00001; exp_info[2] = 5'b00010;
        exp_id[3] = 5'b00001; exp_info[3] = 5'b00011;
        // Head must hold while not ready.
        chk("bp_hold_id", out_e_id_o, exp_id[0]);
        out_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("bp_pop%0d_valid", j), out_valid_o, 1'b1);
            chk($sformatf("bp_pop%0d_id", j), out_e_id_o, exp_id[j]);
            chk($sformatf("bp_pop%0d_info", j), out_e_info_o, exp_info[j]);
            tick();
        end
        out_ready_i = 1'b0;
        chk("bp_empty", out_valid_o, 1'b0);

        // Full FIFO, push and pop on the same edge: accepted, no drop.
        fire_burst(4);
        evt_i = 16'h0008; asid_i = 1'b1; commit_vld_i = 1'b1; pc_commit_i = 64'h8000_0090;
        tick();
        evt_i = '0; asid_i = '0; commit_vld_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        cfg_read(6'h01, rd); chk("pp_dropcnt", rd, 32'd2);
        exp_id[0] = 5'b00001; exp_info[0] = 5'b00011;
        exp_id[1] = 5'b00001; exp_info[1] = 5'b00010;
        exp_id[2] = 5'b00001; exp_info[2] = 5'b00011;
        exp_id[3] = 5'b10001; exp_info[3] = 5'b00011;
        out_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("pp_pop%0d_id", j), out_e_id_o, exp_id[j]);
            chk($sformatf("pp_pop%0d_info", j), out_e_info_o, exp_info[j]);
            tick();
        end
        out_ready_i = 1'b0;
        chk("pp_empty", out_valid_o, 1'b0);

        // Clear on the same edge as a drop: clear wins.
        fire_burst(4);
        evt_i = 16'h0008;
        tick();
        evt_i = '0;
        cfg_we_i = 1'b1; cfg_addr_i = 6'h00; cfg_wdata_i = 32'h0000_0003;
        tick();
        cfg_we_i = 1'b0;
        tick();
        chk("clr_ovf", overflow_o, 1'b0);
        cfg_read(6'h01, rd); chk("clr_dropcnt", rd, 32'd0);
        cfg_read(6'h00, rd); chk("clr_ctrl", rd, 32'h0000_0001);
        chk("clr_full_valid", out_valid_o, 1'b1);
        out_ready_i = 1'b1;
        repeat (4) tick();
        out_ready_i = 1'b0;
        chk("clr_empty", out_valid_o, 1'b0);

        // Asynchronous reset with 3 records queued.
        fire_burst(3);
        chk("ar_valid_before", out_valid_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_valid_async", out_valid_o, 1'b0);
        chk("ar_id_async", out_e_id_o, 5'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        cfg_read(6'h08, rd); chk("ar_ch0", rd, 32'd0);
        cfg_read(6'h20, rd); chk("ar_pc0_lo", rd, 32'd0);
        cfg_read(6'h2A, rd); chk("ar_pc2_hi", rd, 32'd0);
        cfg_read(6'h00, rd); chk("ar_ctrl", rd, 32'd0);
        chk("ar_valid_after", out_valid_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
